ex_stage: RTL

//  Execute stage; consumes the decoded bundle latched by ID_to_EX_Reg and produces a result for the EX->MEM register.
//  RV32IM integer ops: ALU and MUL complete in one cycle; DIV/DIVU/REM/REMU use an iterative radix-2 divider.

---
 rtl/ex_stage.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
//   Execute stage of the RV32IM pipeline. Takes the decoded bundle held in the
//   ID/EX register and produces the value written into the EX/MEM register.
//   ALU and multiply ops finish in the same cycle. DIV/DIVU/REM/REMU run on an
//   iterative restoring divider (one quotient bit per cycle). While it runs,
//   stall_o holds PC, IF/ID and ID/EX.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   valid_i      : ID/EX holds a valid instruction
//   flush_i      : kill the instruction currently in EX
//   alu_op_i     : operation select (ADD..AND, MUL family, DIV family)
//   alu_src_i    : 1 selects imm_i as operand B, 0 selects rs2_data_i
//   rs1_data_i   : operand A
//   rs2_data_i   : operand B from the register file
//   imm_i        : operand B from the immediate
//   rd_addr_i    : destination register
//   RegWrite_i   : writeback enable
//   valid_o      : result_o / rd_addr_o / RegWrite_o are meaningful
//   result_o     : execution result
//   rd_addr_o    : destination register
//   RegWrite_o   : writeback enable, gated by valid_o
//   stall_o      : hold all upstream stages this cycle
// ----------------------------------------------------------------------------
module ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic                      flush_i,
    input  logic [4:0]                alu_op_i,
    input  logic                      alu_src_i,
    input  logic [DATA_WIDTH-1:0]     rs1_data_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [DATA_WIDTH-1:0]     imm_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                      RegWrite_i,
    output logic                      valid_o,
    output logic [DATA_WIDTH-1:0]     result_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      RegWrite_o,
    output logic                      stall_o
);

    localparam int SHW   = $clog2(DATA_WIDTH);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]     op_a, op_b;
    logic [DATA_WIDTH-1:0]     alu_result;
    logic [2*DATA_WIDTH-1:0]   mul_a, mul_b, mul_prod;
    logic                      mul_a_sgn, mul_b_sgn;

    logic                      is_div, is_signed_div, is_rem_op;
    logic                      b_zero, div_overflow, fast_path, start_div;
    logic [DATA_WIDTH-1:0]     fast_result;
    logic [DATA_WIDTH-1:0]     a_abs, b_abs;

    logic [DATA_WIDTH-1:0]     quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      neg_quo_q, neg_rem_q, is_rem_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      we_q;

    logic [DATA_WIDTH:0]       rem_shift, rem_diff;
    logic                      step_ok;
    logic [DATA_WIDTH-1:0]     rem_next, quo_next, div_result;

    assign op_a = rs1_data_i;
    assign op_b = alu_src_i ? imm_i : rs2_data_i;

    // Operand signedness for the multiplier: extending both operands to 2W
    // bits with the right sign lets one unsigned 2W x 2W product (truncated
    // to 2W bits) serve MUL, MULH, MULHSU and MULHU alike.
    assign mul_a_sgn = ((alu_op_i == OP_MULH) || (alu_op_i == OP_MULHSU)) && op_a[DATA_WIDTH-1];
    assign mul_b_sgn = (alu_op_i == OP_MULH) && op_b[DATA_WIDTH-1];
    assign mul_a     = {{DATA_WIDTH{mul_a_sgn}}, op_a};
    assign mul_b     = {{DATA_WIDTH{mul_b_sgn}}, op_b};
    assign mul_prod  = mul_a * mul_b;

    // Single-cycle ALU and multiply results; unknown encodings behave as ADD.
    always_comb begin
        alu_result = op_a + op_b;
        case (alu_op_i)
            OP_SUB:    alu_result = op_a - op_b;
            OP_SLL:    alu_result = op_a << op_b[SHW-1:0];
            OP_SLT:    alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:   alu_result = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
            OP_XOR:    alu_result = op_a ^ op_b;
            OP_SRL:    alu_result = op_a >> op_b[SHW-1:0];
            OP_SRA:    alu_result = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
            OP_OR:     alu_result = op_a | op_b;
            OP_AND:    alu_result = op_a & op_b;
            OP_MUL:    alu_result = mul_prod[DATA_WIDTH-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  alu_result = mul_prod[2*DATA_WIDTH-1:DATA_WIDTH];
            default:   alu_result = op_a + op_b;
        endcase
    end

    // Divide classification. Divide-by-zero and the signed overflow case have
    // architecturally fixed answers, so they bypass the iterative divider.
    assign is_div        = (alu_op_i == OP_DIV) || (alu_op_i == OP_DIVU) ||
                           (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
    assign is_signed_div = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
    assign is_rem_op     = (alu_op_i == OP_REM) || (alu_op_i == OP_REMU);
    assign b_zero        = (op_b == '0);
    assign div_overflow  = is_signed_div && (op_a == MIN_NEG) && (op_b == '1);
    assign fast_path     = b_zero || div_overflow;
    assign start_div     = (state_q == IDLE) && valid_i && !flush_i && is_div && !fast_path;

    always_comb begin
        if (b_zero) begin
            fast_result = is_rem_op ? op_a : '1;
        end else begin
            fast_result = is_rem_op ? '0 : MIN_NEG;
        end
    end

    // The divider works on magnitudes; the signs are reapplied on the way out.
    assign a_abs = (is_signed_div && op_a[DATA_WIDTH-1]) ? (-op_a) : op_a;
    assign b_abs = (is_signed_div && op_b[DATA_WIDTH-1]) ? (-op_b) : op_b;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not go negative.
    assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs_q};
    assign step_ok   = !rem_diff[DATA_WIDTH];
    assign rem_next  = step_ok ? rem_diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
    assign quo_next  = {quo_q[DATA_WIDTH-2:0], step_ok};

    always_comb begin
        if (is_rem_q) begin
            div_result = neg_rem_q ? (-rem_q) : rem_q;
        end else begin
            div_result = neg_quo_q ? (-quo_q) : quo_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A flush abandons a divide in flight without output.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_div) state_d = BUSY;
            BUSY: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(DATA_WIDTH-1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Divider datapath: operands captured at issue, one step per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            rd_q      <= '0;
            we_q      <= 1'b0;
        end else if (start_div) begin
            quo_q     <= a_abs;
            rem_q     <= '0;
            dvs_q     <= b_abs;
            cnt_q     <= '0;
            neg_quo_q <= is_signed_div && (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
            neg_rem_q <= is_signed_div && op_a[DATA_WIDTH-1];
            is_rem_q  <= is_rem_op;
            rd_q      <= rd_addr_i;
            we_q      <= RegWrite_i;
        end else if (state_q == BUSY) begin
            quo_q     <= quo_next;
            rem_q     <= rem_next;
            cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    // Output logic. Reset overrides everything so nothing leaks while rst=1.
    always_comb begin
        valid_o    = 1'b0;
        result_o   = '0;
        rd_addr_o  = '0;
        RegWrite_o = 1'b0;
        stall_o    = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    stall_o    = start_div;
                    valid_o    = valid_i && !flush_i && !start_div;
                    result_o   = is_div ? fast_result : alu_result;
                    rd_addr_o  = rd_addr_i;
                    RegWrite_o = valid_i && !flush_i && !start_div && RegWrite_i;
                end
                BUSY: begin
                    stall_o    = !flush_i;
                    rd_addr_o  = rd_q;
                end
                DONE: begin
                    valid_o    = !flush_i;
                    result_o   = div_result;
                    rd_addr_o  = rd_q;
                    RegWrite_o = !flush_i && we_q;
                end
                default: begin
                    valid_o    = 1'b0;
                end
            endcase
        end
    end

endmodule
